uart_tx_sched: RTL
==================

# uart_tx_sched

Transmit-side scheduler for the UART byte path. It shares one synchronous FIFO between two byte sources, port A (host) and port B (echo/loopback), using round-robin write arbitration. It also drains the FIFO into the UART transmitter over a valid/ready handshake. It sits between the requesters, the `fifo` instance (`push`/`pop`/`data_in`/`data_out`/`fifo_full`/`fifo_empty`) and the serializer.

## Interface
- `DATA_WIDTH`, 8, byte width; must match the FIFO.
- `CNT_WIDTH`, 16, width of the sent-byte counter.

- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `a_valid` / `b_valid`  in  1  requester has a byte.
- `a_data` / `b_data`  in  DATA_WIDTH  requester byte.
- `a_ready` / `b_ready`  out  1  combinational grant; a transfer occurs on an edge where valid and ready are both high.
- `fifo_push`  out  1  FIFO write strobe (combinational).
- `fifo_data_in`  out  DATA_WIDTH  selected requester byte.
- `fifo_pop`  out  1  FIFO read strobe (registered FSM output).
- `fifo_data_out`  in  DATA_WIDTH  FIFO read data; valid on the cycle after `fifo_pop`.
- `fifo_full` / `fifo_empty`  in  1  FIFO status.
- `tx_valid`  out  1  byte offered to the transmitter.
- `tx_data`  out  DATA_WIDTH  byte to transmit (registered).
- `tx_ready`  in  1  transmitter accepts the byte when high together with `tx_valid`.
- `sent_count`  out  CNT_WIDTH  bytes handed to the transmitter; wraps modulo 2^CNT_WIDTH.
- `busy`  out  1  drain FSM is not in IDLE.

## Operation
- **Write arbiter (combinational grant):**
  - 1-bit priority pointer `prio` (0 = A first). Reset value is 0.
  - Eligible only when `fifo_full` = 0. If only one requester is valid, it wins. If both are valid, the `prio` side wins.
  - Winner's ready = 1, `fifo_push` = 1, `fifo_data_in` = winner's data.
  - No grant when `fifo_full` = 1, even if a pop happens in the same cycle.
  - On every accepted transfer, `prio` moves to the non-winner.
  - `fifo_data_in` = `a_data` when no grant is given.
- **Drain FSM, states IDLE, POP, LOAD, SEND:**
  - IDLE: if `fifo_empty` = 0 (and not paused), go to POP.
  - POP: `fifo_pop` = 1 for exactly one cycle, then LOAD.
  - LOAD: capture `fifo_data_out` into `tx_data`, then SEND.
  - SEND: `tx_valid` = 1. Hold `tx_data` stable until `tx_valid && tx_ready`. On that edge, `sent_count` += 1 and the FSM returns to IDLE.
  - `fifo_pop` is never asserted while `fifo_empty` = 1. IDLE samples `fifo_empty`, and only one pop is outstanding at a time, so the FIFO never underflows.
- **Simultaneous events:** a push and a pop in the same cycle are both performed; the FIFO supports it.
- **Reset mid-operation:** the FSM returns to IDLE and any captured byte is discarded. The FIFO is reset by its own reset.
- **Reset values:** `tx_valid` 0, `tx_data` 0, `fifo_pop` 0, `sent_count` 0, `busy` 0, `prio` 0. Ready/push outputs follow the inputs combinationally.

## Timing
- Push latency: 0. The byte is written on the same edge where valid and ready are both high.
- Drain latency: the FIFO becomes non-empty at edge N, then:
  - POP occupies cycle N+1;
  - `tx_data` is loaded at edge N+3;
  - `tx_valid` rises at N+3.
- Best-case throughput is one byte per 4 cycles, which is far above the UART bit rate.
- `sent_count` updates on the handshake edge; `busy` is high from POP through SEND.

## Configuration
- `UART_TX_PAUSE_EN` defined:
  - Adds input `tx_pause` (1 bit).
  - While `tx_pause` = 1, the FSM stays in IDLE and issues no pops.
  - A byte already in POP, LOAD or SEND completes normally.
  - Writes to the FIFO continue.
- `UART_TX_PAUSE_EN` not defined: the port is absent and the block behaves as if `tx_pause` = 0.

## Test plan
- **Reset:** hold `reset` for 2 cycles with `a_valid` = 0. Then `tx_valid` = 0, `fifo_pop` = 0, `sent_count` = 0, `busy` = 0.
- **Single source:** A pushes 0x11, 0x22, 0x33 with `tx_ready` = 1.
  - `tx_data` sequence is 0x11, 0x22, 0x33.
  - Each `tx_valid` starts 3 cycles after the FIFO becomes non-empty or the FSM re-enters IDLE.
  - `sent_count` = 3.
- **Round-robin:** A and B both hold valid, with A bytes 0xA0–0xA3 and B bytes 0xB0–0xB3.
  - FIFO write order is A0, B0, A1, B1, ...
  - `a_ready` and `b_ready` are never high in the same cycle.
- **Full:** with `tx_ready` = 0, A pushes DEPTH=32 bytes, then offers 0xAA.
  - `a_ready` = 0 while `fifo_full` = 1, and 0xAA is not written.
  - The FSM holds in SEND with the first byte.
  - After `tx_ready` rises, 0xAA is accepted once a pop frees an entry.
- **Backpressure + reset:** hold `tx_ready` = 0 in SEND with `tx_data` = 0x5C for 10 cycles.
  - `tx_data` stays 0x5C throughout.
  - Asserting `reset` returns the FSM to IDLE with `tx_valid` = 0 on the next edge.
- **Pause** (`UART_TX_PAUSE_EN`): with `tx_pause` = 1, push 4 bytes.
  - No `fifo_pop`, and `busy` = 0.
  - When `tx_pause` is released, the 4 bytes drain in order and `sent_count` = 4.

Source files
------------

// File: rtl/uart_tx_sched.sv
// Round-robin two-source FIFO write arbiter plus a four-state FIFO-to-UART drain FSM.
// Optional macro UART_TX_PAUSE_EN adds a tx_pause input that holds the drain FSM in IDLE.
module uart_tx_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  a_valid,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  b_ready,
  output logic                  fifo_push,
  output logic [DATA_WIDTH-1:0] fifo_data_in,
  output logic                  fifo_pop,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_full,
  input  logic                  fifo_empty,
  output logic                  tx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_ready,
  output logic [CNT_WIDTH-1:0]  sent_count,
`ifdef UART_TX_PAUSE_EN
  input  logic                  tx_pause,
`endif
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, POP, LOAD, SEND} state_t;

  state_t state;
  logic   prio;
  logic   pause;

`ifdef UART_TX_PAUSE_EN
  assign pause = tx_pause;
`else
  assign pause = 1'b0;
`endif

  // Grant is withheld whenever the FIFO is full, even if a pop lands on the same edge.
  always_comb begin
    a_ready      = 1'b0;
    b_ready      = 1'b0;
    fifo_push    = 1'b0;
    fifo_data_in = a_data;
    if (!fifo_full) begin
      if (a_valid && (!b_valid || !prio)) begin
        a_ready   = 1'b1;
        fifo_push = 1'b1;
      end else if (b_valid) begin
        b_ready      = 1'b1;
        fifo_push    = 1'b1;
        fifo_data_in = b_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prio <= 1'b0;
    end else if (a_ready) begin
      prio <= 1'b1;
    end else if (b_ready) begin
      prio <= 1'b0;
    end
  end

  // Only one pop is ever in flight: IDLE is the sole place that looks at fifo_empty.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      fifo_pop   <= 1'b0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      sent_count <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty && !pause) begin
            state    <= POP;
            fifo_pop <= 1'b1;
            busy     <= 1'b1;
          end
        end
        POP: begin
          state    <= LOAD;
          fifo_pop <= 1'b0;
        end
        LOAD: begin
          state    <= SEND;
          tx_data  <= fifo_data_out;
          tx_valid <= 1'b1;
        end
        SEND: begin
          if (tx_ready) begin
            state      <= IDLE;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            sent_count <= sent_count + CNT_WIDTH'(1);
          end
        end
        default: begin
          state    <= IDLE;
          fifo_pop <= 1'b0;
          tx_valid <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
